// File: rtl/md_sched.sv
// HI/LO multiply/divide sequencer: fixed-latency mult/div, owns HI/LO, drives start/busy/stall.
// Optional madd/msub accumulate ops are enabled by defining MULDIV_MADD_EN.
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        d_md,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        start,
   output logic        busy,
   output logic        stall_md
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MSUB  = 4'd10;
`endif

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [31:0] p_hi;
   logic [31:0] p_lo;

   logic        md_op;
   logic [31:0] lat;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        sdiv;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] num;
   logic [31:0] den;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] div_lo;
   logic [31:0] div_hi;
   logic [63:0] res;

   // Decode which ops launch a timed operation and the counter preload for each.
   always_comb begin
      md_op = 1'b0;
      lat   = 32'(MULT_CYCLES - 1);
      case (op)
         OP_MULT, OP_MULTU: md_op = 1'b1;
         OP_DIV, OP_DIVU: begin
            md_op = 1'b1;
            lat   = 32'(DIV_CYCLES - 1);
         end
`ifdef MULDIV_MADD_EN
         OP_MADD, OP_MSUB: md_op = 1'b1;
`endif
         default: md_op = 1'b0;
      endcase
   end

   // Products and a single magnitude divider; signed division fixes up signs afterwards.
   always_comb begin
      prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      prod_u = {32'd0, A} * {32'd0, B};
      sdiv   = (op == OP_DIV);
      abs_a  = A[31] ? (32'd0 - A) : A;
      abs_b  = B[31] ? (32'd0 - B) : B;
      num    = sdiv ? abs_a : A;
      den    = sdiv ? abs_b : B;
      if (den == 32'd0) begin
         den = 32'd1;
      end else begin
         den = den;
      end
      quo    = num / den;
      rem    = num % den;
      div_lo = (sdiv && (A[31] ^ B[31])) ? (32'd0 - quo) : quo;
      div_hi = (sdiv && A[31]) ? (32'd0 - rem) : rem;
   end

   // Select the pending result; a zero divisor leaves HI/LO as they are.
   always_comb begin
      res = {HI, LO};
      case (op)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV, OP_DIVU: begin
            if (B == 32'd0) begin
               res = {HI, LO};
            end else begin
               res = {div_hi, div_lo};
            end
         end
`ifdef MULDIV_MADD_EN
         OP_MADD: res = {HI, LO} + prod_s;
         OP_MSUB: res = {HI, LO} - prod_s;
`endif
         default: res = {HI, LO};
      endcase
   end

   assign start    = (state == IDLE) & md_op;
   assign stall_md = d_md & (start | busy);

   // Sequencer: launch from IDLE, count down in RUN, commit HI/LO on the last busy cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         cnt   <= 32'd0;
         p_hi  <= 32'd0;
         p_lo  <= 32'd0;
         HI    <= 32'd0;
         LO    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  p_hi  <= res[63:32];
                  p_lo  <= res[31:0];
                  cnt   <= lat;
                  state <= RUN;
                  busy  <= 1'b1;
               end else if (op == OP_MTHI) begin
                  HI <= A;
               end else if (op == OP_MTLO) begin
                  LO <= A;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (cnt == 32'd0) begin
                  HI    <= p_hi;
                  LO    <= p_lo;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes expected HI/LO and busy length, a monitor checks on completion.
module tb_md_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        d_md;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        start;
   logic        busy;
   logic        stall_md;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .op(op), .A(A), .B(B), .d_md(d_md),
      .HI(HI), .LO(LO), .start(start), .busy(busy), .stall_md(stall_md)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int len);
      exp_t e;
      e.hi = hi; e.lo = lo; e.len = len;
      sb.push_back(e);
   endtask

   // Present a launching op for one cycle, starting just after a rising edge.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; A = a; B = b;
      @(negedge clk);
      chk("start", {31'd0, start}, 32'd1);
      @(posedge clk); #1;
      op = 4'd0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      if (!done) chk("idle_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   // Monitor: on each busy fall, compare HI/LO and busy length with the scoreboard.
   initial begin
      int  run_len = 0;
      bit  prev_busy = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            run_len = 0;
            prev_busy = 1'b0;
         end else begin
            if (busy) begin
               run_len++;
            end else if (prev_busy) begin
               if (sb.size() == 0) begin
                  chk("sb_unexpected", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("hi", HI, e.hi);
                  chk("lo", LO, e.lo);
                  chk("busy_len", 32'(run_len), 32'(e.len));
               end
               run_len = 0;
            end
            prev_busy = busy;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; op = 4'd0; A = 32'd0; B = 32'd0; d_md = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_start", {31'd0, start}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      issue(4'd1, 32'hFFFFFFFE, 32'd3);
      wait_idle();

      push(32'hFFFFFFFE, 32'h00000001, 5);
      issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle();

      push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue(4'd3, 32'hFFFFFFF9, 32'd2);
      wait_idle();

      push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue(4'd4, 32'd7, 32'd0);
      wait_idle();

      push(32'h00000000, 32'h80000000, 10);
      issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_idle();

      // mthi then mtlo on consecutive cycles
      op = 4'd5; A = 32'h12345678;
      @(negedge clk);
      chk("mthi_start", {31'd0, start}, 32'd0);
      @(posedge clk); #1;
      op = 4'd6; A = 32'h9ABCDEF0;
      @(negedge clk);
      chk("mthi_hi", HI, 32'h12345678);
      chk("mthi_lo", LO, 32'h80000000);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      op = 4'd0;
      @(negedge clk);
      chk("mtlo_lo", LO, 32'h9ABCDEF0);
      chk("mtlo_hi", HI, 32'h12345678);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;

      // mult with D-stage HI/LO user; a div arriving mid-run must be ignored
      push(32'h00000001, 32'h00000000, 5);
      d_md = 1'b1;
      for (int c = 0; c <= 6; c++) begin
         op = (c == 0) ? 4'd1 : ((c == 3) ? 4'd3 : 4'd0);
         A  = (c == 0) ? 32'h00010000 : 32'd100;
         B  = (c == 0) ? 32'h00010000 : 32'd7;
         @(negedge clk);
         chk($sformatf("stall_c%0d", c), {31'd0, stall_md}, (c <= 5) ? 32'd1 : 32'd0);
         if (c == 0) chk("start_c0", {31'd0, start}, 32'd1);
         if (c == 3) chk("start_ignored", {31'd0, start}, 32'd0);
         @(posedge clk); #1;
      end
      d_md = 1'b0; op = 4'd0;

      // reset in cycle 3 of a div discards it
      issue(4'd3, 32'd100, 32'd7);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_hi", HI, 32'd0);
      chk("rst_mid_lo", LO, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      push(32'd0, 32'd6, 5);
      issue(4'd1, 32'd2, 32'd3);
      wait_idle();

`ifdef MULDIV_MADD_EN
      push(32'd0, 32'd4, 5);
      issue(4'd9, 32'hFFFFFFFF, 32'd2);
      wait_idle();
      push(32'd0, 32'd3, 5);
      issue(4'd10, 32'd1, 32'd1);
      wait_idle();
`else
      for (int k = 0; k < 2; k++) begin
         op = (k == 0) ? 4'd9 : 4'd11; A = 32'd5; B = 32'd5;
         @(negedge clk);
         chk("undef_start", {31'd0, start}, 32'd0);
         @(posedge clk); #1;
         op = 4'd0;
         @(negedge clk);
         chk("undef_busy", {31'd0, busy}, 32'd0);
         chk("undef_hi", HI, 32'd0);
         chk("undef_lo", LO, 32'd6);
         @(posedge clk); #1;
      end
`endif

      repeat (3) @(posedge clk);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
